lsu_mem_ctrl: RTL and testbench

- Load/store controller between the execute stage and the word-addressed data memory.
- Accepts one load/store request at a time over a valid/ready handshake and computes the effective address.
- Checks alignment and range, then performs word accesses. Byte and halfword stores use a two-cycle read-modify-write.
- Returns sign- or zero-extended load data, or an error flag, over a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_mem_ctrl_if.sv | 51 +++++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/lsu_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes,
// fault codes, controller states and the funct3 legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_OOB      = 2'd2,
        ERR_FUNCT3   = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ACCESS,
        WRITE,
        RESP
    } lsu_state_e;

    // Loads accept B/H/W/BU/HU; stores only have B/H/W encodings.
    function automatic logic isLegalFunct3(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundles for the load/store controller: the request/response channel
// from the execute stage and the word-wide data-memory port.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_err_code;

    // Execute stage issues requests and consumes responses.
    modport master (
        output req_valid, req_we, req_funct3, req_base, req_offset, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_err_code
    );

    // The controller accepts requests and produces responses.
    modport slave (
        input  req_valid, req_we, req_funct3, req_base, req_offset, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_err_code
    );
endinterface

interface lsu_mem_if;
    logic [31:0] mem_base;
    logic [31:0] mem_offset;
    logic        mem_r_enabled;
    logic [31:0] mem_r_data;
    logic        mem_w_enabled;
    logic [31:0] mem_w_data;

    // The controller drives address and write strobe.
    modport master (
        output mem_base, mem_offset, mem_r_enabled, mem_w_enabled, mem_w_data,
        input  mem_r_data
    );

    // The memory returns combinational read data.
    modport slave (
        input  mem_base, mem_offset, mem_r_enabled, mem_w_enabled, mem_w_data,
        output mem_r_data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for sub-word accesses: extracts and extends load data
// from a memory word, and merges store data into a word for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addrLo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_loadData,
    output logic [31:0] o_mergedWord
);

    logic [4:0]  w_shAmt;
    logic [31:0] w_shifted;

    assign w_shAmt   = {i_addrLo, 3'b000};
    assign w_shifted = i_word >> w_shAmt;

    // Load path: bring the addressed lane down to bit 0 and extend it.
    always_comb begin
        o_loadData = 32'h0;
        case (i_funct3)
            F3_B:    o_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_loadData = i_word;
            F3_BU:   o_loadData = {24'h0, w_shifted[7:0]};
            F3_HU:   o_loadData = {16'h0, w_shifted[15:0]};
            default: o_loadData = 32'h0;
        endcase
    end

    // Store path: clear the addressed lanes of the old word and insert wdata.
    always_comb begin
        o_mergedWord = i_word;
        case (i_funct3)
            F3_B: o_mergedWord = (i_word & ~(32'h0000_00FF << w_shAmt)) |
                                 ({24'h0, i_wdata[7:0]} << w_shAmt);
            F3_H: o_mergedWord = (i_word & ~(32'h0000_FFFF << w_shAmt)) |
                                 ({16'h0, i_wdata[15:0]} << w_shAmt);
            F3_W: o_mergedWord = i_wdata;
            default: o_mergedWord = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one request at a time, checks funct3,
// alignment and range, performs the word access (read-modify-write for
// byte/halfword stores) and holds the response until it is consumed.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic   clk,
    input  logic   rst,
    lsu_req_if.slave  req_bus,
    lsu_mem_if.master mem_bus
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    lsu_state_e  r_state;
    logic [31:0] r_ea;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_reqReady;
    logic        r_respValid;
    logic [31:0] r_respRdata;
    logic        r_respErr;
    err_code_e   r_respErrCode;
    logic [31:0] r_memBase;
    logic        r_memRe;
    logic        r_memWe;
    logic [31:0] r_memWData;

    logic [31:0] w_loadData;
    logic [31:0] w_mergedWord;
    logic        w_misaligned;
    err_code_e   w_errCode;

    lsu_lane_align u_lane_align (
        .i_word       (mem_bus.mem_r_data),
        .i_addrLo     (r_ea[1:0]),
        .i_funct3     (r_funct3),
        .i_wdata      (r_wdata),
        .o_loadData   (w_loadData),
        .o_mergedWord (w_mergedWord)
    );

    // Fault classification of the latched request, highest priority first.
    always_comb begin
        w_misaligned = ((r_funct3 == F3_H) || (r_funct3 == F3_HU)) ? r_ea[0] :
                       (r_funct3 == F3_W) ? (r_ea[1:0] != 2'b00) : 1'b0;
        w_errCode = ERR_NONE;
        if (!isLegalFunct3(r_we, r_funct3)) begin
            w_errCode = ERR_FUNCT3;
        end else if (w_misaligned) begin
            w_errCode = ERR_MISALIGN;
        end else if (r_ea >= MEM_BYTES) begin
            w_errCode = ERR_OOB;
        end
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ea          <= 32'h0;
            r_we          <= 1'b0;
            r_funct3      <= 3'd0;
            r_wdata       <= 32'h0;
            r_reqReady    <= 1'b1;
            r_respValid   <= 1'b0;
            r_respRdata   <= 32'h0;
            r_respErr     <= 1'b0;
            r_respErrCode <= ERR_NONE;
            r_memBase     <= 32'h0;
            r_memRe       <= 1'b0;
            r_memWe       <= 1'b0;
            r_memWData    <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_bus.req_valid && r_reqReady) begin
                        r_ea       <= req_bus.req_base + req_bus.req_offset;
                        r_we       <= req_bus.req_we;
                        r_funct3   <= req_bus.req_funct3;
                        r_wdata    <= req_bus.req_wdata;
                        r_reqReady <= 1'b0;
                        r_state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_errCode != ERR_NONE) begin
                        r_respErr     <= 1'b1;
                        r_respErrCode <= w_errCode;
                        r_respValid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_memBase <= {r_ea[31:2], 2'b00};
                        r_memRe   <= 1'b1;
                        if (r_we && (r_funct3 == F3_W)) begin
                            r_memWe    <= 1'b1;
                            r_memWData <= r_wdata;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_memRe <= 1'b0;
                    r_memWe <= 1'b0;
                    if (!r_we) begin
                        r_respRdata <= w_loadData;
                        r_respValid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_funct3 == F3_W) begin
                        r_respValid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_memWe    <= 1'b1;
                        r_memWData <= w_mergedWord;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    r_memWe     <= 1'b0;
                    r_respValid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (req_bus.resp_ready) begin
                        r_respValid   <= 1'b0;
                        r_respRdata   <= 32'h0;
                        r_respErr     <= 1'b0;
                        r_respErrCode <= ERR_NONE;
                        r_reqReady    <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_bus.req_ready     = r_reqReady;
    assign req_bus.resp_valid    = r_respValid;
    assign req_bus.resp_rdata    = r_respRdata;
    assign req_bus.resp_err      = r_respErr;
    assign req_bus.resp_err_code = r_respErrCode;

    assign mem_bus.mem_base      = r_memBase;
    assign mem_bus.mem_offset    = 32'h0;
    assign mem_bus.mem_r_enabled = r_memRe;
    // Gated by reset so a write already staged for this cycle is dropped.
    assign mem_bus.mem_w_enabled = r_memWe && !rst;
    assign mem_bus.mem_w_data    = r_memWData;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl with a 1024-word behavioural memory.
module tb_lsu_mem_ctrl;

    logic clk;
    logic rst;

    lsu_req_if reqBus ();
    lsu_mem_if memBus ();

    lsu_mem_ctrl #(.MEM_WORDS(1024)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_bus (reqBus),
        .mem_bus (memBus)
    );

    logic [31:0] memArr [0:1023];
    int          compared;
    int          mismatched;
    int          wrCount;
    logic [31:0] lastWrBase;
    logic [31:0] lastWrData;

    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
    int          writes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memBus.mem_r_data = memArr[memBus.mem_base[11:2]];

    // Behavioural memory write port plus a log of every write strobe.
    always @(posedge clk) begin
        if (memBus.mem_w_enabled) begin
            memArr[memBus.mem_base[11:2]] = memBus.mem_w_data;
            wrCount    = wrCount + 1;
            lastWrBase = memBus.mem_base;
            lastWrData = memBus.mem_w_data;
        end
    end

    // Issue one request from IDLE, measure latency and capture the response.
    task automatic transact(input logic we, input logic [2:0] f3,
                            input logic [31:0] base, input logic [31:0] off,
                            input logic [31:0] wd, output int latOut,
                            output logic [31:0] rdOut, output logic errOut,
                            output logic [1:0] codeOut, output int wrOut);
        int startWr;
        startWr = wrCount;
        reqBus.req_valid  = 1'b1;
        reqBus.req_we     = we;
        reqBus.req_funct3 = f3;
        reqBus.req_base   = base;
        reqBus.req_offset = off;
        reqBus.req_wdata  = wd;
        @(posedge clk); #1;
        reqBus.req_valid = 1'b0;
        latOut  = -1;
        rdOut   = 32'hX;
        errOut  = 1'bX;
        codeOut = 2'bX;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (reqBus.resp_valid) begin
                latOut  = n;
                rdOut   = reqBus.resp_rdata;
                errOut  = reqBus.resp_err;
                codeOut = reqBus.resp_err_code;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wrOut = wrCount - startWr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        compared++;
        if (memBus.mem_w_enabled !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_wen_in_rst: got %b want 0", memBus.mem_w_enabled);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (reqBus.req_ready !== 1'b1) begin
            mismatched++; $display("[TB] FAIL reset_req_ready: got %b want 1", reqBus.req_ready);
        end
        compared++;
        if ({reqBus.resp_valid, reqBus.resp_err, reqBus.resp_err_code} !== 4'b0) begin
            mismatched++; $display("[TB] FAIL reset_resp_flags: got %b want 0000",
                                   {reqBus.resp_valid, reqBus.resp_err, reqBus.resp_err_code});
        end
        compared++;
        if (reqBus.resp_rdata !== 32'h0) begin
            mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", reqBus.resp_rdata);
        end
        compared++;
        if ({memBus.mem_r_enabled, memBus.mem_w_enabled} !== 2'b00) begin
            mismatched++; $display("[TB] FAIL reset_mem_en: got %b want 00",
                                   {memBus.mem_r_enabled, memBus.mem_w_enabled});
        end
        compared++;
        if ({memBus.mem_base, memBus.mem_w_data, memBus.mem_offset} !== 96'h0) begin
            mismatched++; $display("[TB] FAIL reset_mem_bus: base %h wdata %h offset %h want 0",
                                   memBus.mem_base, memBus.mem_w_data, memBus.mem_offset);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw_lw();
        transact(1'b1, 3'd2, 32'h100, 32'h4, 32'hDEADBEEF, lat, rdata, err, code, writes);
        compared++;
        if (lat !== 3) begin
            mismatched++; $display("[TB] FAIL sw_latency: got %0d want 3", lat);
        end
        compared++;
        if (writes !== 1 || lastWrBase !== 32'h104 || lastWrData !== 32'hDEADBEEF) begin
            mismatched++; $display("[TB] FAIL sw_write: got %0d writes base %h data %h want 1 104 deadbeef",
                                   writes, lastWrBase, lastWrData);
        end
        compared++;
        if (err !== 1'b0 || rdata !== 32'h0) begin
            mismatched++; $display("[TB] FAIL sw_resp: got err %b rdata %h want 0 0", err, rdata);
        end
        transact(1'b0, 3'd2, 32'h100, 32'h4, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (lat !== 3 || rdata !== 32'hDEADBEEF || writes !== 0) begin
            mismatched++; $display("[TB] FAIL lw_readback: got lat %0d rdata %h writes %0d want 3 deadbeef 0",
                                   lat, rdata, writes);
        end
    endtask

    task automatic test_subword();
        transact(1'b1, 3'd0, 32'h100, 32'h5, 32'hFFFFFF12, lat, rdata, err, code, writes);
        compared++;
        if (lat !== 4 || writes !== 1 || lastWrData !== 32'hDEAD12EF || memArr[10'h41] !== 32'hDEAD12EF) begin
            mismatched++; $display("[TB] FAIL sb_merge: got lat %0d writes %0d data %h mem %h want 4 1 dead12ef",
                                   lat, writes, lastWrData, memArr[10'h41]);
        end
        transact(1'b0, 3'd0, 32'h105, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (rdata !== 32'h00000012) begin
            mismatched++; $display("[TB] FAIL lb_105: got %h want 00000012", rdata);
        end
        transact(1'b0, 3'd4, 32'h107, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (rdata !== 32'h000000DE) begin
            mismatched++; $display("[TB] FAIL lbu_107: got %h want 000000de", rdata);
        end
        transact(1'b0, 3'd1, 32'h106, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (rdata !== 32'hFFFFDEAD) begin
            mismatched++; $display("[TB] FAIL lh_106: got %h want ffffdead", rdata);
        end
        transact(1'b1, 3'd1, 32'h106, 32'h0, 32'h1234BEEF, lat, rdata, err, code, writes);
        compared++;
        if (lat !== 4 || memArr[10'h41] !== 32'hBEEF12EF) begin
            mismatched++; $display("[TB] FAIL sh_merge: got lat %0d mem %h want 4 beef12ef", lat, memArr[10'h41]);
        end
        transact(1'b0, 3'd0, 32'h104, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (rdata !== 32'hFFFFFFEF) begin
            mismatched++; $display("[TB] FAIL lb_sign: got %h want ffffffef", rdata);
        end
        transact(1'b0, 3'd5, 32'h106, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (rdata !== 32'h0000BEEF) begin
            mismatched++; $display("[TB] FAIL lhu_106: got %h want 0000beef", rdata);
        end
        transact(1'b0, 3'd2, 32'h10C, 32'hFFFFFFF8, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (rdata !== 32'hBEEF12EF || err !== 1'b0) begin
            mismatched++; $display("[TB] FAIL lw_neg_offset: got %h err %b want beef12ef 0", rdata, err);
        end
    endtask

    task automatic test_faults();
        memArr[10'h40] = 32'h11223344;
        memArr[10'h3FF] = 32'h0BADF00D;
        transact(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (lat !== 2 || err !== 1'b1 || code !== 2'd1 || rdata !== 32'h0 || writes !== 0) begin
            mismatched++; $display("[TB] FAIL lw_misalign: got lat %0d err %b code %0d rdata %h writes %0d want 2 1 1 0 0",
                                   lat, err, code, rdata, writes);
        end
        transact(1'b1, 3'd1, 32'h101, 32'h0, 32'hAAAA5555, lat, rdata, err, code, writes);
        compared++;
        if (code !== 2'd1 || writes !== 0 || memArr[10'h40] !== 32'h11223344) begin
            mismatched++; $display("[TB] FAIL sh_misalign: got code %0d writes %0d mem %h want 1 0 11223344",
                                   code, writes, memArr[10'h40]);
        end
        transact(1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (lat !== 2 || err !== 1'b1 || code !== 2'd2) begin
            mismatched++; $display("[TB] FAIL lw_oob: got lat %0d err %b code %0d want 2 1 2", lat, err, code);
        end
        transact(1'b0, 3'd2, 32'hFFC, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (lat !== 3 || err !== 1'b0 || rdata !== 32'h0BADF00D) begin
            mismatched++; $display("[TB] FAIL lw_last_word: got lat %0d err %b rdata %h want 3 0 0badf00d",
                                   lat, err, rdata);
        end
        transact(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (err !== 1'b1 || code !== 2'd3 || writes !== 0) begin
            mismatched++; $display("[TB] FAIL load_f3_3: got err %b code %0d writes %0d want 1 3 0", err, code, writes);
        end
        transact(1'b1, 3'd4, 32'h1001, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (err !== 1'b1 || code !== 2'd3 || writes !== 0) begin
            mismatched++; $display("[TB] FAIL store_f3_4: got err %b code %0d writes %0d want 1 3 0", err, code, writes);
        end
        transact(1'b0, 3'd1, 32'h1001, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (code !== 2'd1) begin
            mismatched++; $display("[TB] FAIL misalign_over_oob: got code %0d want 1", code);
        end
    endtask

    task automatic test_back_to_back();
        int startWr;
        startWr = wrCount;
        reqBus.resp_ready = 1'b0;
        reqBus.req_valid  = 1'b1;
        reqBus.req_we     = 1'b0;
        reqBus.req_funct3 = 3'd2;
        reqBus.req_base   = 32'h104;
        reqBus.req_offset = 32'h0;
        @(posedge clk); #1;
        reqBus.req_we     = 1'b1;
        reqBus.req_base   = 32'h200;
        reqBus.req_wdata  = 32'hCAFEF00D;
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (reqBus.resp_valid !== 1'b1 || reqBus.resp_rdata !== 32'hBEEF12EF || reqBus.req_ready !== 1'b0 ||
                memBus.mem_w_enabled !== 1'b0 || memBus.mem_r_enabled !== 1'b0) begin
                mismatched++; $display("[TB] FAIL stall_cycle%0d: got valid %b rdata %h ready %b ren %b wen %b want 1 beef12ef 0 0 0",
                                       i, reqBus.resp_valid, reqBus.resp_rdata, reqBus.req_ready,
                                       memBus.mem_r_enabled, memBus.mem_w_enabled);
            end
            @(posedge clk); #1;
        end
        reqBus.resp_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (reqBus.req_ready !== 1'b0) begin
            mismatched++; $display("[TB] FAIL release_ready_early: got %b want 0", reqBus.req_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (reqBus.req_ready !== 1'b1 || reqBus.resp_valid !== 1'b0 || reqBus.resp_rdata !== 32'h0) begin
            mismatched++; $display("[TB] FAIL release_idle: got ready %b valid %b rdata %h want 1 0 0",
                                   reqBus.req_ready, reqBus.resp_valid, reqBus.resp_rdata);
        end
        @(posedge clk); #1;
        reqBus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (memBus.mem_w_enabled !== 1'b1 || memBus.mem_base !== 32'h200) begin
            mismatched++; $display("[TB] FAIL b2b_sw_access: got wen %b base %h want 1 200",
                                   memBus.mem_w_enabled, memBus.mem_base);
        end
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (reqBus.resp_valid !== 1'b1 || reqBus.resp_err !== 1'b0) begin
            mismatched++; $display("[TB] FAIL b2b_sw_resp: got valid %b err %b want 1 0",
                                   reqBus.resp_valid, reqBus.resp_err);
        end
        @(posedge clk); #1;
        compared++;
        if (memArr[10'h80] !== 32'hCAFEF00D || (wrCount - startWr) !== 1) begin
            mismatched++; $display("[TB] FAIL b2b_sw_mem: got mem %h writes %0d want cafef00d 1",
                                   memArr[10'h80], wrCount - startWr);
        end
    endtask

    task automatic test_reset_mid_write();
        int startWr;
        memArr[10'h60] = 32'h55667788;
        startWr = wrCount;
        reqBus.req_valid  = 1'b1;
        reqBus.req_we     = 1'b1;
        reqBus.req_funct3 = 3'd1;
        reqBus.req_base   = 32'h182;
        reqBus.req_offset = 32'h0;
        reqBus.req_wdata  = 32'h0000AAAA;
        @(posedge clk); #1;
        reqBus.req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (memBus.mem_w_enabled !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rst_write_gate: got wen %b want 0", memBus.mem_w_enabled);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (reqBus.req_ready !== 1'b1 || reqBus.resp_valid !== 1'b0 || memBus.mem_w_enabled !== 1'b0 ||
            memBus.mem_r_enabled !== 1'b0 || memBus.mem_base !== 32'h0 || memBus.mem_w_data !== 32'h0) begin
            mismatched++; $display("[TB] FAIL rst_outputs: got ready %b valid %b wen %b ren %b base %h wdata %h want 1 0 0 0 0 0",
                                   reqBus.req_ready, reqBus.resp_valid, memBus.mem_w_enabled,
                                   memBus.mem_r_enabled, memBus.mem_base, memBus.mem_w_data);
        end
        compared++;
        if ((wrCount - startWr) !== 0 || memArr[10'h60] !== 32'h55667788) begin
            mismatched++; $display("[TB] FAIL rst_no_write: got writes %0d mem %h want 0 55667788",
                                   wrCount - startWr, memArr[10'h60]);
        end
        @(posedge clk); #1;
        transact(1'b0, 3'd2, 32'h180, 32'h0, 32'h0, lat, rdata, err, code, writes);
        compared++;
        if (lat !== 3 || rdata !== 32'h55667788) begin
            mismatched++; $display("[TB] FAIL rst_readback: got lat %0d rdata %h want 3 55667788", lat, rdata);
        end
    endtask

    // Sequence the scenarios and print the tally.
    initial begin
        compared   = 0;
        mismatched = 0;
        wrCount    = 0;
        lastWrBase = 32'h0;
        lastWrData = 32'h0;
        for (int i = 0; i < 1024; i++) memArr[i] = 32'h0;
        rst               = 1'b1;
        reqBus.req_valid  = 1'b0;
        reqBus.req_we     = 1'b0;
        reqBus.req_funct3 = 3'd0;
        reqBus.req_base   = 32'h0;
        reqBus.req_offset = 32'h0;
        reqBus.req_wdata  = 32'h0;
        reqBus.resp_ready = 1'b1;

        test_reset();
        test_sw_lw();
        test_subword();
        test_faults();
        test_back_to_back();
        test_reset_mid_write();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
